// File: rtl/color_decode.sv
// Palette colour decoder: matches a 12-bit RGB pixel against eight fixed entries,
// registers the result behind a valid/ready stage and counts unmatched pixels per frame.
module color_decode #(
  parameter int TOL   = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [11:0]      in_color,
  input  logic             in_sof,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2:0]       out_type,
  output logic             out_match,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_count,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [11:0] palette(input logic [2:0] k);
    case (k)
      3'd0:    return 12'h666;
      3'd1:    return 12'h0FF;
      3'd2:    return 12'hFF0;
      3'd3:    return 12'hC0C;
      3'd4:    return 12'h0F0;
      3'd5:    return 12'hF00;
      3'd6:    return 12'h00F;
      default: return 12'hF70;
    endcase
  endfunction

  // Distance is taken on 5 bits so a small channel minus a large entry never wraps.
  function automatic logic ch_match(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] d;
    d = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    return (d <= 5'(TOL));
  endfunction

  function automatic logic entry_match(input logic [11:0] c, input logic [11:0] e);
    return ch_match(c[11:8], e[11:8]) && ch_match(c[7:4], e[7:4]) &&
           ch_match(c[3:0], e[3:0]);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  endfunction

  logic [2:0]       type_p0;
  logic             match_p0;
  logic             xfer_p0;
  logic [2:0]       type_p1;
  logic             match_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] err_p1;
  logic             done_p1;
  logic             started;

  // Stage p0: combinational decode; scanning downward leaves the lowest matching index.
  always_comb begin
    type_p0  = 3'd0;
    match_p0 = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (entry_match(in_color, palette(3'(k)))) begin
        type_p0  = 3'(k);
        match_p0 = 1'b1;
      end
    end
  end

  assign in_ready = !vld_p1 || out_ready;
  assign xfer_p0  = in_valid && in_ready;

  // Stage p1: single output register; reloads whenever the slot is empty or being drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      type_p1  <= 3'd0;
      match_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        type_p1  <= type_p0;
        match_p1 <= match_p0;
      end
    end
  end

  // Frame accounting follows input transfers only, so output stalls never skew counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt <= '0;
      err_p1  <= '0;
      done_p1 <= 1'b0;
      started <= 1'b0;
    end else begin
      done_p1 <= 1'b0;
      if (xfer_p0) begin
        if (in_sof) begin
          err_p1  <= started ? run_cnt : '0;
          done_p1 <= 1'b1;
          started <= 1'b1;
          run_cnt <= match_p0 ? '0 : CNT_ONE;
        end else if (!match_p0) begin
          run_cnt <= sat_inc(run_cnt);
        end
      end
    end
  end

  assign out_type   = type_p1;
  assign out_match  = match_p1;
  assign out_valid  = vld_p1;
  assign err_count  = err_p1;
  assign frame_done = done_p1;

endmodule

// File: tb/tb_color_decode.sv
// Directed bench for color_decode: three instances (TOL 0/1/2, CNT_W 16/16/4) share stimulus.
module tb_color_decode;

  logic        clk;
  logic        rst;
  logic [11:0] in_color;
  logic        in_sof;
  logic        in_valid;
  logic        out_ready;

  logic        a_ready, a_match, a_valid, a_done;
  logic [2:0]  a_type;
  logic [15:0] a_err;
  logic        b_ready, b_match, b_valid, b_done;
  logic [2:0]  b_type;
  logic [15:0] b_err;
  logic        c_ready, c_match, c_valid, c_done;
  logic [2:0]  c_type;
  logic [3:0]  c_err;

  int nvec = 0;
  int nerr = 0;

  color_decode #(.TOL(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_color(in_color), .in_sof(in_sof), .in_valid(in_valid),
    .in_ready(a_ready), .out_type(a_type), .out_match(a_match), .out_valid(a_valid),
    .out_ready(out_ready), .err_count(a_err), .frame_done(a_done)
  );

  color_decode #(.TOL(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_color(in_color), .in_sof(in_sof), .in_valid(in_valid),
    .in_ready(b_ready), .out_type(b_type), .out_match(b_match), .out_valid(b_valid),
    .out_ready(out_ready), .err_count(b_err), .frame_done(b_done)
  );

  color_decode #(.TOL(2), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .in_color(in_color), .in_sof(in_sof), .in_valid(in_valid),
    .in_ready(c_ready), .out_type(c_type), .out_match(c_match), .out_valid(c_valid),
    .out_ready(out_ready), .err_count(c_err), .frame_done(c_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_color = 12'h000; out_ready = 1'b1;
    step();
    step();
    nvec++;
    if ({a_valid, b_valid, c_valid} !== 3'b000) begin
      $display("FAIL reset_valid got %b exp 000", {a_valid, b_valid, c_valid}); nerr++;
    end
    nvec++;
    if ({a_done, b_done, c_done} !== 3'b000) begin
      $display("FAIL reset_done got %b exp 000", {a_done, b_done, c_done}); nerr++;
    end
    nvec++;
    if (a_err !== 16'd0 || b_err !== 16'd0 || c_err !== 4'd0) begin
      $display("FAIL reset_err got %0d/%0d/%0d exp 0/0/0", a_err, b_err, c_err); nerr++;
    end
    nvec++;
    if ({a_ready, b_ready, c_ready} !== 3'b111) begin
      $display("FAIL reset_ready got %b exp 111", {a_ready, b_ready, c_ready}); nerr++;
    end
    nvec++;
    if (a_type !== 3'd0 || a_match !== 1'b0) begin
      $display("FAIL reset_type got %0d/%b exp 0/0", a_type, a_match); nerr++;
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_palette;
    logic [11:0] pal [8];
    pal[0] = 12'h666; pal[1] = 12'h0FF; pal[2] = 12'hFF0; pal[3] = 12'hC0C;
    pal[4] = 12'h0F0; pal[5] = 12'hF00; pal[6] = 12'h00F; pal[7] = 12'hF70;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_color = pal[i]; in_valid = 1'b1;
      step();
      nvec++;
      if (a_valid !== 1'b1 || a_type !== 3'(i) || a_match !== 1'b1) begin
        $display("FAIL palette_%0d got v=%b t=%0d m=%b exp v=1 t=%0d m=1",
                 i, a_valid, a_type, a_match, i);
        nerr++;
      end
    end
    in_valid = 1'b0;
    step();
    nvec++;
    if (a_valid !== 1'b0) begin
      $display("FAIL drain_valid got %b exp 0", a_valid); nerr++;
    end
  endtask

  task automatic test_tolerance;
    out_ready = 1'b1; in_valid = 1'b1;
    in_color = 12'h123;
    step();
    nvec++;
    if (a_valid !== 1'b1 || a_type !== 3'd0 || a_match !== 1'b0) begin
      $display("FAIL nomatch_123 got v=%b t=%0d m=%b exp v=1 t=0 m=0", a_valid, a_type, a_match);
      nerr++;
    end
    in_color = 12'h1EE;
    step();
    nvec++;
    if (b_type !== 3'd1 || b_match !== 1'b1) begin
      $display("FAIL tol1_1EE got t=%0d m=%b exp t=1 m=1", b_type, b_match); nerr++;
    end
    nvec++;
    if (a_match !== 1'b0) begin
      $display("FAIL tol0_1EE got m=%b exp m=0", a_match); nerr++;
    end
    in_color = 12'hE1D;
    step();
    nvec++;
    if (b_type !== 3'd0 || b_match !== 1'b0) begin
      $display("FAIL tol1_E1D got t=%0d m=%b exp t=0 m=0", b_type, b_match); nerr++;
    end
    nvec++;
    if (c_type !== 3'd3 || c_match !== 1'b1) begin
      $display("FAIL tol2_E1D got t=%0d m=%b exp t=3 m=1", c_type, c_match); nerr++;
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1; in_valid = 1'b1; in_color = 12'h0FF;
    step();
    out_ready = 1'b0; in_color = 12'hFF0;
    #1;
    nvec++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      $display("FAIL stall_ready_now got %b%b exp 00", a_ready, b_ready); nerr++;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++;
      if (a_ready !== 1'b0 || a_valid !== 1'b1 || a_type !== 3'd1 || a_match !== 1'b1) begin
        $display("FAIL stall_hold_%0d got r=%b v=%b t=%0d m=%b exp r=0 v=1 t=1 m=1",
                 i, a_ready, a_valid, a_type, a_match);
        nerr++;
      end
    end
    out_ready = 1'b1;
    step();
    nvec++;
    if (a_valid !== 1'b1 || a_type !== 3'd2) begin
      $display("FAIL release_1 got v=%b t=%0d exp v=1 t=2", a_valid, a_type); nerr++;
    end
    in_color = 12'hC0C;
    step();
    nvec++;
    if (a_valid !== 1'b1 || a_type !== 3'd3) begin
      $display("FAIL release_2 got v=%b t=%0d exp v=1 t=3", a_valid, a_type); nerr++;
    end
    in_valid = 1'b0;
    step();
    nvec++;
    if (a_valid !== 1'b0) begin
      $display("FAIL release_drain got v=%b exp 0", a_valid); nerr++;
    end
  endtask

  task automatic test_frame;
    logic [11:0] px [10];
    px[0] = 12'h666; px[1] = 12'h123; px[2] = 12'h0FF; px[3] = 12'h123; px[4] = 12'hFF0;
    px[5] = 12'hC0C; px[6] = 12'h123; px[7] = 12'h0F0; px[8] = 12'hF00; px[9] = 12'h00F;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_color = px[i]; in_sof = (i == 0);
      step();
      nvec++;
      if (i == 0) begin
        if (a_done !== 1'b1 || a_err !== 16'd0) begin
          $display("FAIL first_sof got d=%b e=%0d exp d=1 e=0", a_done, a_err); nerr++;
        end
      end else if (a_done !== 1'b0) begin
        $display("FAIL frame_px_%0d got d=%b exp d=0", i, a_done); nerr++;
      end
    end
    in_color = 12'h123; in_sof = 1'b1;
    step();
    nvec++;
    if (a_done !== 1'b1 || a_err !== 16'd3) begin
      $display("FAIL frame_err3 got d=%b e=%0d exp d=1 e=3", a_done, a_err); nerr++;
    end
    in_color = 12'h0FF;
    step();
    nvec++;
    if (a_done !== 1'b1 || a_err !== 16'd1) begin
      $display("FAIL frame_err1 got d=%b e=%0d exp d=1 e=1", a_done, a_err); nerr++;
    end
    in_valid = 1'b0;
    step();
    nvec++;
    if (a_done !== 1'b0 || a_err !== 16'd1) begin
      $display("FAIL sof_no_xfer got d=%b e=%0d exp d=0 e=1", a_done, a_err); nerr++;
    end
    in_sof = 1'b0;
  endtask

  task automatic test_saturate;
    out_ready = 1'b1; in_valid = 1'b1;
    in_color = 12'h666; in_sof = 1'b1;
    step();
    in_sof = 1'b0; in_color = 12'h123;
    repeat (20) step();
    in_color = 12'h666; in_sof = 1'b1;
    step();
    nvec++;
    if (c_done !== 1'b1 || c_err !== 4'd15) begin
      $display("FAIL sat_cnt4 got d=%b e=%0d exp d=1 e=15", c_done, c_err); nerr++;
    end
    nvec++;
    if (a_err !== 16'd20 || b_done !== 1'b1) begin
      $display("FAIL cnt16_20 got e=%0d d=%b exp e=20 d=1", a_err, b_done); nerr++;
    end
    in_valid = 1'b0; in_sof = 1'b0;
    step();
  endtask

  task automatic test_reset_stall;
    out_ready = 1'b0; in_valid = 1'b1; in_color = 12'h0FF;
    step();
    nvec++;
    if (a_valid !== 1'b1 || a_err !== 16'd20) begin
      $display("FAIL prestall got v=%b e=%0d exp v=1 e=20", a_valid, a_err); nerr++;
    end
    #2 rst = 1'b1;
    #1;
    nvec++;
    if ({a_valid, b_valid, c_valid} !== 3'b000 || a_err !== 16'd0 || a_done !== 1'b0) begin
      $display("FAIL async_rst got v=%b%b%b e=%0d d=%b exp v=000 e=0 d=0",
               a_valid, b_valid, c_valid, a_err, a_done);
      nerr++;
    end
    nvec++;
    if (a_ready !== 1'b1 || c_err !== 4'd0) begin
      $display("FAIL async_rst_rdy got r=%b ce=%0d exp r=1 ce=0", a_ready, c_err); nerr++;
    end
    in_valid = 1'b0;
    step();
    rst = 1'b0; out_ready = 1'b1;
    step();
    nvec++;
    if (a_valid !== 1'b0) begin
      $display("FAIL rst_discard got v=%b exp 0", a_valid); nerr++;
    end
    in_valid = 1'b1; in_color = 12'hF70;
    step();
    nvec++;
    if (a_valid !== 1'b1 || a_type !== 3'd7 || a_match !== 1'b1) begin
      $display("FAIL post_rst got v=%b t=%0d m=%b exp v=1 t=7 m=1", a_valid, a_type, a_match);
      nerr++;
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_color = 12'h000; out_ready = 1'b1;
    test_reset();
    test_palette();
    test_tolerance();
    test_back_to_back();
    test_frame();
    test_saturate();
    test_reset_stall();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
